// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control word driven each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       trap;
  } ctrl_t;

  // States whose exit unconditionally retires an instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_MEMWB) || (s == S_RTYPEWB) || (s == S_BRANCH) ||
           (s == S_JUMP)  || (s == S_ADDIWB);
  endfunction

endpackage

// File: rtl/mips_retire_counter.sv
// Retired-instruction counter; wraps modulo 2^COUNT_WIDTH.
module mips_retire_counter #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: Moore strobes, memory
// handshake, branch PC enable, illegal-opcode trap and retire counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   zero,
  input  logic                   memReady,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   pcEn,
  output logic [1:0]             PCSource,
  output logic                   IorD,
  output logic                   MemToReg,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             aluOp,
  output logic                   memReq,
  output logic                   memWe,
  output logic                   trap,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  live;
  logic   retire_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Moore control word; FETCH strobes qualified by memReady.
  always_comb begin
    state_next = state;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = memReady;
        ctrl.pc_write  = memReady;
        if (memReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.i_or_d  = 1'b1;
        if (memReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.i_or_d  = 1'b1;
        if (memReady) state_next = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
        state_next     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_next     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        state_next         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_next     = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        state_next     = S_FETCH;
      end
      S_TRAP: begin
        ctrl.trap  = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset blanks every output at once so an in-flight request drops immediately.
  always_comb begin
    live        = reset ? ctrl : '0;
    PCWrite     = live.pc_write;
    PCWriteCond = live.pc_write_cond;
    pcEn        = live.pc_write | (live.pc_write_cond & zero);
    PCSource    = live.pc_source;
    IorD        = live.i_or_d;
    MemToReg    = live.mem_to_reg;
    IRWrite     = live.ir_write;
    RegWrite    = live.reg_write;
    RegDst      = live.reg_dst;
    ALUSrcA     = live.alu_src_a;
    ALUSrcB     = live.alu_src_b;
    aluOp       = live.alu_op;
    memReq      = live.mem_req;
    memWe       = live.mem_we;
    trap        = live.trap;
  end

  assign retire_en = reset &
                     (is_retire_state(state) | ((state == S_MEMWR) & memReady));

  mips_retire_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (reset),
    .en    (retire_en),
    .count (instrCount)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with a 4-bit retire counter.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CW = 4;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3,
                 T_MEMWB = 4, T_MEMWR = 5, T_EXEC = 6, T_RTYPEWB = 7,
                 T_BRANCH = 8, T_JUMP = 9, T_ADDIEX = 10, T_ADDIWB = 11,
                 T_TRAP = 12, T_OFF = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op;
  logic          zero;
  logic          memReady;
  logic          PCWrite, PCWriteCond, pcEn, IorD, MemToReg, IRWrite;
  logic          RegWrite, RegDst, ALUSrcA, memReq, memWe, trap;
  logic [1:0]    PCSource, ALUSrcB, aluOp;
  logic [CW-1:0] instrCount;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] exp_cnt;
  logic [18:0]   obs;

  mips_multicycle_ctrl #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pcEn(pcEn),
    .PCSource(PCSource), .IorD(IorD), .MemToReg(MemToReg), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .aluOp(aluOp), .memReq(memReq), .memWe(memWe),
    .trap(trap), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, pcEn, PCSource, IorD, MemToReg, IRWrite,
                RegWrite, RegDst, ALUSrcA, ALUSrcB, aluOp, memReq, memWe, trap};

  // Expected output word for a state, written straight from the state table.
  function automatic logic [18:0] exp_sig(input int s, input logic mr, input logic z);
    logic pcw, pcwc, iord, m2r, irw, rw, rd, srca, mreq, mwe, tr;
    logic [1:0] pcs, srcb, aop;
    {pcw, pcwc, iord, m2r, irw, rw, rd, srca, mreq, mwe, tr} = '0;
    pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
    case (s)
      T_FETCH:   begin mreq = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      T_DECODE:  srcb = 2'b11;
      T_MEMADR:  begin srca = 1; srcb = 2'b10; end
      T_MEMRD:   begin mreq = 1; iord = 1; end
      T_MEMWB:   begin m2r = 1; rw = 1; end
      T_MEMWR:   begin mreq = 1; mwe = 1; iord = 1; end
      T_EXEC:    begin srca = 1; aop = 2'b10; end
      T_RTYPEWB: begin rd = 1; rw = 1; end
      T_BRANCH:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      T_JUMP:    begin pcw = 1; pcs = 2'b10; end
      T_ADDIEX:  begin srca = 1; srcb = 2'b10; end
      T_ADDIWB:  rw = 1;
      T_TRAP:    tr = 1;
      default:   ;
    endcase
    return {pcw, pcwc, pcw | (pcwc & z), pcs, iord, m2r, irw, rw, rd, srca,
            srcb, aop, mreq, mwe, tr};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance to edge+1.
  task automatic cyc(input int s, input logic mr, input logic z, input string tag);
    memReady = mr;
    zero     = z;
    #1;
    check(tag, 32'(obs), 32'(exp_sig(s, mr, z)));
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check(tag, 32'(instrCount), 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; op = 6'b0; zero = 1'b0; memReady = 1'b1; exp_cnt = '0;
    #2;
    check("reset_outputs", 32'(obs), 32'(exp_sig(T_OFF, 1'b1, 1'b0)));
    check_cnt("reset_count");
    @(posedge clk); #1;
    reset = 1'b1;

    // LW, no wait states: 5 cycles, write-back from memory in cycle 5
    op = 6'b100011;
    cyc(T_FETCH, 1, 0, "lw_fetch");
    cyc(T_DECODE, 1, 0, "lw_decode");
    cyc(T_MEMADR, 1, 0, "lw_memadr");
    cyc(T_MEMRD, 1, 0, "lw_memrd");
    cyc(T_MEMWB, 1, 0, "lw_memwb");
    exp_cnt = exp_cnt + CW'(1);
    check_cnt("lw_count");

    // SW with three wait cycles in MEMWR
    op = 6'b101011;
    cyc(T_FETCH, 1, 0, "sw_fetch");
    cyc(T_DECODE, 1, 0, "sw_decode");
    cyc(T_MEMADR, 1, 0, "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(T_MEMWR, 0, 0, "sw_memwr_wait");
    check_cnt("sw_count_held");
    cyc(T_MEMWR, 1, 0, "sw_memwr_ready");
    exp_cnt = exp_cnt + CW'(1);
    check_cnt("sw_count");

    // BEQ taken then not taken
    op = 6'b000100;
    cyc(T_FETCH, 1, 0, "beq1_fetch");
    cyc(T_DECODE, 1, 1, "beq1_decode");
    cyc(T_BRANCH, 1, 1, "beq1_branch_taken");
    exp_cnt = exp_cnt + CW'(1);
    cyc(T_FETCH, 1, 0, "beq2_fetch");
    cyc(T_DECODE, 1, 0, "beq2_decode");
    cyc(T_BRANCH, 1, 0, "beq2_branch_not_taken");
    exp_cnt = exp_cnt + CW'(1);
    check_cnt("beq_count");

    // Fetch stalled 5 cycles, then an R-type
    op = 6'b000000;
    for (int i = 0; i < 5; i++) cyc(T_FETCH, 0, 0, "fetch_stall");
    cyc(T_FETCH, 1, 0, "fetch_ready");
    cyc(T_DECODE, 0, 0, "rtype_decode");
    cyc(T_EXEC, 0, 0, "rtype_exec");
    cyc(T_RTYPEWB, 0, 0, "rtype_wb");
    exp_cnt = exp_cnt + CW'(1);
    check_cnt("rtype_count");

    // ADDI
    op = 6'b001000;
    cyc(T_FETCH, 1, 0, "addi_fetch");
    cyc(T_DECODE, 1, 0, "addi_decode");
    cyc(T_ADDIEX, 1, 0, "addi_ex");
    cyc(T_ADDIWB, 1, 0, "addi_wb");
    exp_cnt = exp_cnt + CW'(1);
    check_cnt("addi_count");

    // 17 jumps carry the 4-bit counter across its wrap point
    op = 6'b000010;
    for (int i = 0; i < 17; i++) begin
      cyc(T_FETCH, 1, 0, "j_fetch");
      cyc(T_DECODE, 1, 0, "j_decode");
      cyc(T_JUMP, 1, 0, "j_jump");
      exp_cnt = exp_cnt + CW'(1);
      check_cnt(exp_cnt == '0 ? "j_count_wrap" : "j_count");
    end
    check("j_final_count", 32'(instrCount), 32'd7);

    // SW interrupted by reset while waiting in MEMWR
    op = 6'b101011;
    cyc(T_FETCH, 1, 0, "swr_fetch");
    cyc(T_DECODE, 1, 0, "swr_decode");
    cyc(T_MEMADR, 1, 0, "swr_memadr");
    memReady = 1'b0;
    #1;
    check("swr_memwr", 32'(obs), 32'(exp_sig(T_MEMWR, 1'b0, 1'b0)));
    #1;
    reset = 1'b0;
    #1;
    check("swr_memreq_drop", 32'(memReq), 32'd0);
    check("swr_outputs_off", 32'(obs), 32'(exp_sig(T_OFF, 1'b0, 1'b0)));
    exp_cnt = '0;
    check_cnt("swr_count_clear");
    @(posedge clk); #1;
    reset = 1'b1;
    op = 6'b000010;
    cyc(T_FETCH, 1, 0, "swr_after_fetch");
    cyc(T_DECODE, 1, 0, "swr_after_decode");
    cyc(T_JUMP, 1, 0, "swr_after_jump");
    exp_cnt = exp_cnt + CW'(1);
    check_cnt("swr_after_count");

    // Illegal opcode traps and sticks
    op = 6'b111111;
    cyc(T_FETCH, 1, 0, "trap_fetch");
    cyc(T_DECODE, 1, 0, "trap_decode");
    for (int i = 0; i < 100; i++)
      cyc(T_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "trap_hold");
    check_cnt("trap_count_frozen");
    reset = 1'b0;
    #1;
    check("trap_reset_outputs", 32'(obs), 32'(exp_sig(T_OFF, 1'b1, 1'b0)));
    @(posedge clk); #1;
    reset = 1'b1;
    exp_cnt = '0;
    check_cnt("trap_reset_count");
    op = 6'b000100;
    cyc(T_FETCH, 1, 0, "trap_release_fetch");
    check("trap_cleared", 32'(trap), 32'd0);
    cyc(T_DECODE, 1, 0, "trap_release_decode");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the 32-bit multicycle MIPS core. It sits directly upstream of the datapath and drives every datapath control strobe from the opcode the datapath returns.
- Also owns the memory request handshake, conditional-PC-enable generation, an illegal-opcode trap and a retired-instruction counter.
- One instance per core; the ALU controller consumes aluOp.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- op  in  6  opcode from instruction register.
- zero  in  1  ALU zero flag (combinational, current cycle).
- memReady  in  1  memory completes the current request this cycle.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  branch PC write request.
- pcEn  out  1  PCWrite | (PCWriteCond & zero); the datapath PC enable.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemToReg  out  1  1 = register write data from memory register.
- IRWrite  out  1  load instruction register.
- RegWrite  out  1  register file write.
- RegDst  out  1  1 = rd, 0 = rt.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- aluOp  out  2  00 add, 01 sub, 10 decode funct.
- memReq  out  1  memory access request.
- memWe  out  1  write qualifier for memReq.
- trap  out  1  sticky illegal-opcode flag.
- instrCount  out  COUNT_WIDTH  retired instructions, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, instrCount=0, trap=0. While in reset, all outputs are forced to 0, including memReq.
- Outputs decode from the registered state (Moore). The only exceptions are IRWrite/PCWrite in FETCH and the retire increment, which are qualified by memReady in the same cycle.
- Any output not listed for a state is 0.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- FETCH:
  - Outputs: memReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, aluOp=00, PCSource=00.
  - IRWrite=PCWrite=memReady.
  - Holds in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, aluOp=00.
  - Next state by op: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX, any other→TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, aluOp=00. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: memReq=1, IorD=1. Holds until memReady=1, then goes to MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Next FETCH.
- MEMWR: memReq=1, memWe=1, IorD=1. Holds until memReady=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, aluOp=10. Next RTYPEWB.
- RTYPEWB: RegDst=1, MemToReg=0, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, aluOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, aluOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Next FETCH.
- TRAP:
  - All strobes 0; trap=1.
  - Stays in TRAP until reset; trap is cleared only by reset.
- Retire: instrCount increments by 1 on the edge that leaves MEMWB, RTYPEWB, BRANCH, JUMP or ADDIWB, and on the edge that leaves MEMWR with memReady=1.
  - Wraps from all-ones to 0.
  - A trapped instruction is not counted.
- Latency in cycles with zero memory wait:
  - LW 5
  - SW 4
  - R-type 4
  - ADDI 4
  - BEQ 3
  - J 3
  - Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds 1.
- memReady outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-access drops the request immediately; no partial write is retried.

Decomposition:
- Package mips_ctrl_pkg holds the state enumeration (4-bit, 13 states), the opcode constants, the aluOp constants, and the ALUSrcB/PCSource select constants.
- One natural sub-module, mips_retire_counter: the COUNT_WIDTH counter with increment enable and asynchronous active-low clear.

Test Plan:
- Reset then LW (op=100011), memReady=1 always → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 with MemToReg=1 exactly in cycle 5; instrCount 0→1.
- SW with memReady low 3 cycles in MEMWR → memReq=memWe=1 held 4 cycles; FETCH entered after the ready cycle; RegWrite never 1; instrCount +1.
- BEQ with zero=1, then BEQ with zero=0 → pcEn=1 only in the BRANCH cycle of the first; second gives pcEn=0 and PCWriteCond=1.
- FETCH with memReady=0 for 5 cycles → IRWrite=PCWrite=0 throughout; both 1 only in the ready cycle; then DECODE.
- op=111111 at DECODE → TRAP; trap=1 sticky for 100 cycles with all strobes 0 and instrCount frozen; reset=0 clears to FETCH and trap=0.
- Preload instrCount near wrap (COUNT_WIDTH=4), run 17 J instructions; assert reset=0 mid-MEMWR of a following SW → count wraps 15→0; memReq drops asynchronously; state=FETCH after release.
